pc_fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 21 ++
 rtl/pc_fetch_unit.sv | 102 ++++++++++
 tb/tb_pc_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared front-end types and constants for the PC fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Architectural PC register, instruction-memory request and
//            misaligned-redirect trap for the CPU front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ready_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic            fetch_valid_o,
   output logic [XLEN-1:0] fetch_pc_o,
   output logic            misalign_o,
   output logic [XLEN-1:0] misalign_pc_o
);

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic [XLEN-1:0] pc_plus4;
   logic            fetch_valid, fetch_valid_nxt;
   logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
   logic            misalign, misalign_nxt;
   logic [XLEN-1:0] misalign_pc, misalign_pc_nxt;

   // Modulo-2^XLEN increment: the top word wraps to zero silently.
   assign pc_plus4 = pc + XLEN'(INSTR_BYTES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         pc          <= RESET_PC[XLEN-1:0];
         fetch_valid <= 1'b0;
         fetch_pc    <= '0;
         misalign    <= 1'b0;
         misalign_pc <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         fetch_valid <= fetch_valid_nxt;
         fetch_pc    <= fetch_pc_nxt;
         misalign    <= misalign_nxt;
         misalign_pc <= misalign_pc_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      fetch_valid_nxt = 1'b0;
      fetch_pc_nxt    = fetch_pc;
      misalign_nxt    = misalign;
      misalign_pc_nxt = misalign_pc;

      case (state)
         BOOT: state_nxt = FETCH;
         FETCH: begin
            // Redirect outranks stall and ready; a misaligned target traps.
            if (redirect_i) begin
               if (redirect_pc_i[1:0] != 2'b00) begin
                  misalign_nxt    = 1'b1;
                  misalign_pc_nxt = redirect_pc_i;
                  state_nxt       = HALT;
               end else begin
                  pc_nxt = redirect_pc_i;
               end
            end else if (!stall_i && imem_ready_i) begin
               pc_nxt          = pc_plus4;
               fetch_valid_nxt = 1'b1;
               fetch_pc_nxt    = pc;
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = BOOT;
      endcase
   end

   assign imem_req_o    = (state == FETCH);
   assign imem_addr_o   = pc;
   assign pc_o          = pc;
   assign pc_plus4_o    = pc_plus4;
   assign fetch_valid_o = fetch_valid;
   assign fetch_pc_o    = fetch_pc;
   assign misalign_o    = misalign;
   assign misalign_pc_o = misalign_pc;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ready;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        misalign;
   logic [31:0] misalign_pc;

   int total = 0;
   int bad   = 0;

   // Behavioural model: "mode" is booting / running / trapped.
   localparam int M_BOOTING = 0, M_RUNNING = 1, M_TRAPPED = 2;
   int          m_mode;
   logic [31:0] m_pc, m_fpc, m_mispc;
   logic        m_fv, m_mis;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ready_i  (ready),
      .pc_o          (pc),
      .pc_plus4_o    (pc_plus4),
      .fetch_valid_o (fetch_valid),
      .fetch_pc_o    (fetch_pc),
      .misalign_o    (misalign),
      .misalign_pc_o (misalign_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_mode  = M_BOOTING;
      m_pc    = 32'h0;
      m_fv    = 1'b0;
      m_fpc   = 32'h0;
      m_mis   = 1'b0;
      m_mispc = 32'h0;
   endtask

   task automatic model_edge();
      m_fv = 1'b0;
      if (m_mode == M_BOOTING) begin
         m_mode = M_RUNNING;
      end else if (m_mode == M_RUNNING) begin
         if (redirect && (redirect_pc % 4) != 0) begin
            m_mis   = 1'b1;
            m_mispc = redirect_pc;
            m_mode  = M_TRAPPED;
         end else if (redirect) begin
            m_pc = redirect_pc;
         end else if (!stall && ready) begin
            m_fpc = m_pc;
            m_pc  = m_pc + 32'd4;
            m_fv  = 1'b1;
         end
      end
   endtask

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic s, input logic r, input logic [31:0] t, input logic rdy);
      stall       = s;
      redirect    = r;
      redirect_pc = t;
      ready       = rdy;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      rst_n = 1'b0;
      #3;
      model_reset();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
      total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_plus4 got=%h exp=4", pc_plus4); end
      total++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h0) begin bad++;
         $display("FAIL reset_fetch got=%b/%h exp=0/0", fetch_valid, fetch_pc); end
      total++; if (misalign !== 1'b0 || misalign_pc !== 32'h0) begin bad++;
         $display("FAIL reset_misalign got=%b/%h exp=0/0", misalign, misalign_pc); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_req got=%b exp=0", imem_req); end
      cycle();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_valid !== 1'b0) begin bad++;
         $display("FAIL first_fetch got req=%b addr=%h fv=%b exp 1/0/0", imem_req, imem_addr, fetch_valid); end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 3; i++) begin
         cycle();
         total++;
         if (imem_addr !== 32'(4 * (i + 1)) || fetch_valid !== 1'b1 || fetch_pc !== 32'(4 * i)) begin
            bad++;
            $display("FAIL seq_%0d got addr=%h fv=%b fpc=%h exp addr=%h fv=1 fpc=%h",
                     i, imem_addr, fetch_valid, fetch_pc, 32'(4 * (i + 1)), 32'(4 * i));
         end
      end
      cycle();
   endtask

   task automatic test_stall();
      total++; if (pc !== 32'h10) begin bad++; $display("FAIL stall_start got=%h exp=10", pc); end
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         total++;
         if (imem_addr !== 32'h10 || imem_req !== 1'b1 || fetch_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_%0d got addr=%h req=%b fv=%b exp 10/1/0", i, imem_addr, imem_req, fetch_valid);
         end
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      cycle();
      total++; if (imem_addr !== 32'h14 || fetch_valid !== 1'b1 || fetch_pc !== 32'h10) begin bad++;
         $display("FAIL stall_resume got addr=%h fv=%b fpc=%h exp 14/1/10", imem_addr, fetch_valid, fetch_pc); end
   endtask

   task automatic test_redirect();
      drive(1'b1, 1'b1, 32'h200, 1'b1);
      cycle();
      total++; if (pc !== 32'h200 || fetch_valid !== 1'b0) begin bad++;
         $display("FAIL redirect got pc=%h fv=%b exp 200/0", pc, fetch_valid); end
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      cycle();
      total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h200 || pc !== 32'h204) begin bad++;
         $display("FAIL redirect_fire got fv=%b fpc=%h pc=%h exp 1/200/204", fetch_valid, fetch_pc, pc); end
      // Waiting on memory: address must hold.
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      cycle();
      total++; if (imem_addr !== 32'h204 || fetch_valid !== 1'b0 || imem_req !== 1'b1) begin bad++;
         $display("FAIL wait_hold got addr=%h fv=%b req=%b exp 204/0/1", imem_addr, fetch_valid, imem_req); end
   endtask

   task automatic test_wrap();
      drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      cycle();
      total++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin bad++;
         $display("FAIL wrap_top got pc=%h plus4=%h exp fffffffc/0", pc, pc_plus4); end
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      cycle();
      total++; if (pc !== 32'h0 || pc_plus4 !== 32'h4 || fetch_pc !== 32'hFFFF_FFFC || misalign !== 1'b0) begin bad++;
         $display("FAIL wrap got pc=%h plus4=%h fpc=%h mis=%b exp 0/4/fffffffc/0", pc, pc_plus4, fetch_pc, misalign); end
   endtask

   task automatic test_misalign();
      logic [31:0] held;
      held = pc;
      drive(1'b0, 1'b1, 32'h202, 1'b1);
      cycle();
      total++; if (misalign !== 1'b1 || misalign_pc !== 32'h202 || imem_req !== 1'b0 || pc !== held || fetch_valid !== 1'b0) begin bad++;
         $display("FAIL misalign got mis=%b mpc=%h req=%b pc=%h fv=%b exp 1/202/0/%h/0",
                  misalign, misalign_pc, imem_req, pc, fetch_valid, held); end
      drive(1'b0, 1'b1, 32'h300, 1'b1);
      cycle();
      cycle();
      total++; if (pc !== held || misalign_pc !== 32'h202 || imem_req !== 1'b0) begin bad++;
         $display("FAIL halt_ignore got pc=%h mpc=%h req=%b exp %h/202/0", pc, misalign_pc, imem_req, held); end
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      do_reset();
      #1;
      total++; if (misalign !== 1'b0 || misalign_pc !== 32'h0) begin bad++;
         $display("FAIL misalign_clear got %b/%h exp 0/0", misalign, misalign_pc); end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      cycle();
      cycle();
      cycle();
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      total++; if (imem_req !== 1'b0 || pc !== 32'h0 || fetch_valid !== 1'b0 || fetch_pc !== 32'h0) begin bad++;
         $display("FAIL async_reset got req=%b pc=%h fv=%b fpc=%h exp 0/0/0/0", imem_req, pc, fetch_valid, fetch_pc); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [31:0] tgt;
      for (int n = 0; n < 400; n++) begin
         if (n % 80 == 79) begin
            do_reset();
         end
         tgt = {$urandom_range(0, 255), 2'b00} << 2;
         if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
         drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), tgt,
               1'($urandom_range(0, 2) != 0));
         cycle();
         total++;
         if (imem_req !== (m_mode == M_RUNNING) || imem_addr !== m_pc || pc !== m_pc ||
             pc_plus4 !== m_pc + 32'd4 || fetch_valid !== m_fv || fetch_pc !== m_fpc ||
             misalign !== m_mis || misalign_pc !== m_mispc) begin
            bad++;
            $display("FAIL random_%0d got req=%b pc=%h p4=%h fv=%b fpc=%h mis=%b mpc=%h exp req=%b pc=%h fv=%b fpc=%h mis=%b mpc=%h",
                     n, imem_req, pc, pc_plus4, fetch_valid, fetch_pc, misalign, misalign_pc,
                     (m_mode == M_RUNNING), m_pc, m_fv, m_fpc, m_mis, m_mispc);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      model_reset();
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_wrap();
      test_misalign();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
